tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter between N_REQ result producers. Each producer offers a 16-bit word.
- The block grants one requester at a time and latches its word. It then sequences a 3-byte frame into the UART using the tx_start/tx_busy handshake: header (source ID), low byte, high byte.
- Sits between the computation blocks and uart_tx, and replaces per-source byte-sending control.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- HDR_TAG, 5'b10100, upper 5 bits of the header byte; header = {HDR_TAG, id[2:0]}.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset: asserted when 0, sampled on the rising edge of clk.
- req  input  N_REQ  per-requester request; held high with stable data until ack.
- req_data  input  16*N_REQ  requester i word on bits [16*i+15 : 16*i].
- ack  output  N_REQ  one-cycle pulse to the granted requester when its word is latched.
- tx_busy  input  1  UART transmitter busy flag.
- tx_start  output  1  registered start request to the UART.
- tx_data  output  8  registered byte to the UART; stable while tx_start=1.
- busy  output  1  high whenever the state is not IDLE.
- grant_id  output  3  ID of the requester being serviced; holds the last value in IDLE.

Behaviour:
- Reset (reset=0 at an edge), all values next cycle:
  - state=IDLE, tx_start=0, tx_data=0, ack=0, busy=0, grant_id=0.
  - Hold register=0, byte index=0, rr pointer=N_REQ-1, so requester 0 has first priority.
- Reset has priority over every other event, including mid-frame. The frame is abandoned and is not resumed.
- States: IDLE, SEND, WAIT_DONE.
- IDLE:
  - If any req bit is 1 at edge t, the winner is the first requester with req=1 in the order ptr+1, ptr+2, … (mod N_REQ).
  - At edge t: hold<=req_data[winner]; grant_id<=winner; ptr<=winner; byte index<=0; state<=SEND.
  - During cycle t+1: ack[winner]=1 for exactly that cycle; tx_start=1; tx_data={HDR_TAG, winner}.
- SEND:
  - tx_start remains 1 and tx_data stays constant until tx_busy=1 is sampled.
  - On that edge: tx_start<=0, state<=WAIT_DONE.
  - No timeout applies.
- WAIT_DONE:
  - Waits for tx_busy=0, then increments the byte index.
  - Index 1: tx_data<=hold[7:0], tx_start<=1, state<=SEND.
  - Index 2: tx_data<=hold[15:8], tx_start<=1, state<=SEND.
  - After byte 2 completes: state<=IDLE, tx_start=0. tx_data keeps its last value.
- Byte order on the line: header, low, high. Exactly 3 tx_start assertion episodes per grant.
- Requests raised while busy stay pending and are not acknowledged. They are arbitrated in the first IDLE cycle after the frame (one idle cycle minimum between frames).
- A req still high in the cycle after its ack is treated as a new request. Requesters must drop req on seeing ack.
- Requests from the current winner are skipped in favour of others by pointer order. Fairness: with all requesters asserting, grants rotate 0,1,2,…,N_REQ-1,0.
- A requester dropping req before ack is not an error. It is considered only if req=1 at the arbitration edge.
- ack is never asserted for more than one requester or for more than one cycle per grant.

Test Plan:
- Reset check: hold reset=0 for 3 cycles, then release → tx_start=0, tx_data=0, ack=0, busy=0, grant_id=0.
- Single request with a UART model (busy rises 2 cycles after tx_start and lasts 10 cycles): req[2]=1, word 16'hBEEF → ack[2] pulses 1 cycle after the request is sampled; bytes sent are 8'hA2, 8'hEF, 8'hBE; busy returns to 0 after the third byte; exactly 3 tx_start episodes.
- Round-robin: all 4 req held, each dropped on ack, words 16'h1000+i → frames from IDs 0,1,2,3 in order. Re-raise req[0] and req[3] after the first pass → the next grant goes to 0, then 3.
- Slow UART: tx_busy rises 20 cycles after tx_start → tx_start stays 1 and tx_data unchanged for all 20 cycles, then drops on the edge after busy=1 is sampled.
- Reset mid-frame: assert reset=0 while in WAIT_DONE after the low byte → next cycle state IDLE, tx_start=0; a pending req[1] is granted fresh after release, starting with header 8'hA1.
- Late request: req[3] rises during another frame → no ack until that frame ends; ack[3] arrives in the cycle after the first post-frame IDLE edge.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter
//   Round-robin scheduler sharing one UART transmitter between N_REQ result
//   producers. The winning requester's 16-bit word is latched and sent as a
//   3-byte frame: header {HDR_TAG, id}, low byte, high byte. Each byte uses
//   the tx_start / tx_busy handshake of uart_tx.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-low reset
//   req       per-requester request, held with stable data until ack
//   req_data  requester i word on bits [16*i+15 : 16*i]
//   ack       one-cycle pulse to the granted requester when its word is latched
//   tx_busy   UART transmitter busy flag
//   tx_start  registered start request to the UART
//   tx_data   registered byte to the UART, stable while tx_start=1
//   busy      high whenever a frame is in progress
//   grant_id  ID of the requester being serviced, held while idle
module tx_arbiter #(
  parameter int         N_REQ   = 4,
  parameter logic [4:0] HDR_TAG = 5'b10100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic [2:0]          grant_id
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [15:0]      hold, hold_d;
  logic [1:0]       byte_idx, byte_idx_d;
  logic [2:0]       ptr, ptr_d;
  logic [2:0]       grant_d;
  logic             tx_start_d;
  logic [7:0]       tx_data_d;
  logic [N_REQ-1:0] ack_d;

  // Round-robin search. Requesters above the pointer come first (lowest
  // index wins), then wrap around to the lowest requester at or below it.
  logic        found_hi;
  logic [2:0]  win_hi, win_lo, winner;
  logic [15:0] win_word;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (3'(i) > ptr) begin
          found_hi = 1'b1;
          win_hi   = 3'(i);
        end else begin
          win_lo = 3'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;

    win_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == winner) win_word = req_data[16*i +: 16];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    hold_d     = hold;
    byte_idx_d = byte_idx;
    ptr_d      = ptr;
    grant_d    = grant_id;
    tx_start_d = tx_start;
    tx_data_d  = tx_data;
    ack_d      = '0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          hold_d     = win_word;
          grant_d    = winner;
          ptr_d      = winner;
          byte_idx_d = '0;
          tx_start_d = 1'b1;
          tx_data_d  = {HDR_TAG, winner};
          state_d    = SEND;
          for (int i = 0; i < N_REQ; i++) ack_d[i] = (3'(i) == winner);
        end
      end

      // Hold the start request until the UART acknowledges by going busy.
      SEND: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end

      // Byte finished once busy drops; queue the next byte or end the frame.
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx == 2'd2) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx + 2'd1;
            tx_data_d  = (byte_idx == 2'd0) ? hold[7:0] : hold[15:8];
            tx_start_d = 1'b1;
            state_d    = SEND;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state    <= IDLE;
      hold     <= '0;
      byte_idx <= '0;
      ptr      <= 3'(N_REQ - 1);
      grant_id <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ack      <= '0;
    end else begin
      state    <= state_d;
      hold     <= hold_d;
      byte_idx <= byte_idx_d;
      ptr      <= ptr_d;
      grant_id <= grant_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
      ack      <= ack_d;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
`timescale 1ns/1ps
module tb_tx_arbiter;

  localparam int         N   = 4;
  localparam logic [4:0] TAG = 5'b10100;

  logic            clk      = 1'b0;
  logic            reset    = 1'b0;
  logic [N-1:0]    req      = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]    ack;
  logic            tx_busy  = 1'b0;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            busy;
  logic [2:0]      grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tx_arbiter #(.N_REQ(N), .HDR_TAG(TAG)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .grant_id (grant_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- UART model ----------------
  int uart_delay = 2;
  int uart_len   = 10;
  bit uart_rand  = 0;
  int ep_delay   = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_start) begin
        ep_delay = uart_rand ? int'($urandom_range(1, 4)) : uart_delay;
        repeat (ep_delay) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (uart_rand ? int'($urandom_range(1, 6)) : uart_len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // ---------------- Reference model ----------------
  // Tracks frames at the transaction level: one arbitration per idle edge
  // with a pending request, then busy until the third UART byte completes.
  bit           chk_en  = 0;
  int           m_ptr   = N - 1;
  bit           m_busy  = 0;
  int           m_grant = 0;
  logic [N-1:0] m_ack   = '0;
  bit           m_seen  = 0;
  int           m_done  = 0;
  int           m_w;
  logic [15:0]  m_word;
  logic [8:0]   exp_q[$];

  always @(posedge clk) begin
    m_ack = '0;
    if (!reset) begin
      chk_en  = 1;
      m_busy  = 0;
      m_ptr   = N - 1;
      m_grant = 0;
      m_seen  = 0;
      m_done  = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (req != '0) begin
        m_w = -1;
        for (int k = 1; k <= N; k++) begin
          if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
        end
        m_ptr    = m_w;
        m_grant  = m_w;
        m_busy   = 1;
        m_seen   = 0;
        m_done   = 0;
        m_ack[m_w] = 1'b1;
        m_word   = req_data[16*m_w +: 16];
        exp_q.push_back({1'b0, TAG, 3'(m_w)});
        exp_q.push_back({1'b0, m_word[7:0]});
        exp_q.push_back({1'b0, m_word[15:8]});
      end
    end else begin
      if (tx_busy) m_seen = 1;
      else if (m_seen) begin
        m_seen = 0;
        m_done++;
        if (m_done == 3) m_busy = 0;
      end
    end
  end

  // ---------------- Output monitor ----------------
  logic [7:0] sent[$];
  int         dut_grants[$];
  logic       prev_start = 1'b0;
  logic [7:0] ep_byte    = '0;
  int         ep_len     = 0;
  int         last_len   = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 32'(ack), 32'(m_ack));
      check("busy", 32'(busy), 32'(m_busy));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      for (int i = 0; i < N; i++) if (ack[i]) dut_grants.push_back(i);
      if (tx_start && !prev_start) begin
        sent.push_back(tx_data);
        ep_byte = tx_data;
        ep_len  = 1;
        check("tx_byte", 32'(tx_data), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h1FF);
      end else if (tx_start) begin
        check("tx_data_stable", 32'(tx_data), 32'(ep_byte));
        ep_len++;
      end else if (prev_start && reset) begin
        last_len = ep_len;
        check("start_len", 32'(ep_len), 32'(ep_delay + 1));
      end
      prev_start = tx_start;
    end
  end

  // ---------------- Stimulus ----------------
  bit rand_mode = 0;

  // Advance one cycle; inputs change 1ns after the edge. Requesters drop
  // req on seeing ack, and in random mode raise/drop requests at will.
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !ack[i] && $urandom_range(0, 7) == 0) begin
          req_data[16*i +: 16] = 16'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic raise(input int id, input logic [15:0] word);
    req_data[16*id +: 16] = word;
    req[id] = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit early;
    int n;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);

    // Single request, word BEEF from requester 2
    sent.delete();
    raise(2, 16'hBEEF);
    tick();
    check("single_ack", 32'(ack), 32'b0100);
    wait_idle("single", 200);
    check("single_nbytes", 32'(sent.size()), 32'd3);
    check("single_hdr", 32'(sent[0]), 32'hA2);
    check("single_lo", 32'(sent[1]), 32'hEF);
    check("single_hi", 32'(sent[2]), 32'hBE);
    check("single_len", 32'(last_len), 32'd3);

    // Round robin from reset: all four request together
    do_reset();
    dut_grants.delete();
    for (int i = 0; i < N; i++) raise(i, 16'(16'h1000 + i));
    n = 0;
    while ((dut_grants.size() < 4 || busy) && n < 400) begin tick(); n++; end
    check("rr_count", 32'(dut_grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("rr_order", 32'(dut_grants[i]), 32'(i));
    dut_grants.delete();
    raise(3, 16'h2003);
    raise(0, 16'h2000);
    n = 0;
    while ((dut_grants.size() < 2 || busy) && n < 200) begin tick(); n++; end
    check("rr2_count", 32'(dut_grants.size()), 32'd2);
    check("rr2_first", 32'(dut_grants[0]), 32'd0);
    check("rr2_second", 32'(dut_grants[1]), 32'd3);

    // Slow UART: busy rises 20 cycles after tx_start
    uart_delay = 20;
    sent.delete();
    raise(1, 16'h5A5A);
    tick();
    wait_idle("slow", 400);
    check("slow_len", 32'(last_len), 32'd21);
    check("slow_nbytes", 32'(sent.size()), 32'd3);
    uart_delay = 2;

    // Reset mid-frame, in WAIT_DONE after the low byte
    sent.delete();
    dut_grants.delete();
    raise(0, 16'h1234);
    tick();
    raise(1, 16'hCAFE);
    n = 0;
    while (!(sent.size() >= 2 && !tx_start && tx_busy) && n < 200) begin tick(); n++; end
    check("mid_reached", 32'(sent.size()), 32'd2);
    reset = 1'b0;
    tick();
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    n = 0;
    while (tx_busy && n < 50) begin tick(); n++; end
    tick();
    reset = 1'b1;
    sent.delete();
    tick();
    check("mid_regrant_ack", 32'(ack), 32'b0010);
    wait_idle("mid", 200);
    check("mid_hdr", 32'(sent[0]), 32'hA1);
    check("mid_lo", 32'(sent[1]), 32'hFE);
    check("mid_hi", 32'(sent[2]), 32'hCA);

    // Late request during another frame
    raise(2, 16'h7777);
    tick();
    repeat (3) tick();
    raise(3, 16'h3333);
    early = 0;
    n = 0;
    while (busy && n < 200) begin
      tick();
      if (ack[3]) early = 1;
      n++;
    end
    check("late_no_early_ack", 32'(early), 32'd0);
    tick();
    check("late_ack", 32'(ack), 32'b1000);
    wait_idle("late", 200);

    // Randomized traffic against the model
    uart_rand = 1;
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    n = 0;
    while ((req != '0 || busy) && n < 3000) begin tick(); n++; end
    check("rand_drain", 32'(req != '0 || busy), 32'd0);
    check("rand_bytes_left", 32'(exp_q.size()), 32'd0);
    uart_rand = 0;

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
